avalon_mm_mem_tester: RTL and testbench

- Avalon-MM master (initiator) that drives the 32-bit, 26-bit-address, single-beat bridge slave port of the SDRAM subsystem.
- On start, it writes a deterministic pattern to a contiguous word region.
- It then reads the region back with pipelined reads, up to MAX_PENDING outstanding, and checks each returned word.
- Reports pass/fail, error count and first failing address; used for board bring-up of the SDRAM path.

---
 rtl/avalon_mm_mem_tester.sv | 161 ++++++++++++++++
 tb/tb_avalon_mm_mem_tester.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mm_mem_tester.sv
// Avalon-MM memory tester: writes a seeded pattern over a word region, reads it back
// with up to MAX_PENDING pipelined reads, and reports error count and first bad address.
module avalon_mm_mem_tester #(
  parameter int                ADDR_W      = 26,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 26'h0,
  parameter int                NUM_WORDS   = 1024,
  parameter int                MAX_PENDING = 4,
  parameter logic [31:0]       SEED        = 32'h5A5A_0000
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       error_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [3:0]        avm_byteenable,
  output logic              avm_burstcount,
  output logic              avm_debugaccess,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int IDX_W = 17;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(NUM_WORDS);
  localparam logic [4:0]       MAX_PEND = 5'(MAX_PENDING);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] wr_idx, rd_idx, chk_idx;
  logic [4:0]       pending;

  logic             wr_acc, rd_acc, active, beat, spur, mismatch;
  logic [4:0]       pending_nxt;
  logic [15:0]      err_nxt;
  logic [IDX_W-1:0] wr_nxt, rd_nxt;

  function automatic logic [DATA_W-1:0] pattern(input logic [15:0] i);
    return DATA_W'({~i, i} ^ SEED);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] i);
    return BASE_ADDR + (ADDR_W'(i) << 2);
  endfunction

  always_comb begin
    wr_acc      = avm_write & ~avm_waitrequest;
    rd_acc      = avm_read & ~avm_waitrequest;
    active      = (state == READ) || (state == DRAIN);
    beat        = active && avm_readdatavalid && (pending != 5'd0);
    spur        = active && avm_readdatavalid && (pending == 5'd0);
    mismatch    = beat && (avm_readdata != pattern(chk_idx[15:0]));
    pending_nxt = pending + 5'(rd_acc) - 5'(beat);
    err_nxt     = error_count;
    if ((mismatch || spur) && (error_count != 16'hFFFF))
      err_nxt = error_count + 16'd1;
    wr_nxt      = wr_idx + 1'b1;
    rd_nxt      = rd_idx + 1'b1;
  end

  assign avm_byteenable  = (avm_read || avm_write) ? 4'hF : 4'h0;
  assign avm_burstcount  = 1'b1;
  assign avm_debugaccess = 1'b0;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state          <= IDLE;
      wr_idx         <= '0;
      rd_idx         <= '0;
      chk_idx        <= '0;
      pending        <= '0;
      error_count    <= '0;
      first_err_addr <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
    end else begin
      // Checker bookkeeping runs in READ/DRAIN only; beat/spur/rd_acc are 0 elsewhere.
      pending     <= pending_nxt;
      error_count <= err_nxt;
      if (beat)
        chk_idx <= chk_idx + 1'b1;
      if (mismatch && (error_count == 16'd0))
        first_err_addr <= addr_of(chk_idx);

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= WRITE;
            wr_idx         <= '0;
            rd_idx         <= '0;
            chk_idx        <= '0;
            pending        <= '0;
            error_count    <= '0;
            first_err_addr <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            avm_write      <= 1'b1;
            avm_address    <= addr_of('0);
            avm_writedata  <= pattern(16'd0);
          end
        end
        WRITE: begin
          if (wr_acc) begin
            wr_idx <= wr_nxt;
            if (wr_idx == LAST_IDX) begin
              avm_write <= 1'b0;
              state     <= READ;
            end else begin
              avm_address   <= addr_of(wr_nxt);
              avm_writedata <= pattern(wr_nxt[15:0]);
            end
          end
        end
        READ: begin
          // A raised read holds until accepted; a new one is issued only with pending headroom.
          if (avm_read) begin
            if (rd_acc) begin
              rd_idx <= rd_nxt;
              if (rd_idx == LAST_IDX) begin
                avm_read <= 1'b0;
                state    <= DRAIN;
              end else if (pending_nxt < MAX_PEND) begin
                avm_address <= addr_of(rd_nxt);
              end else begin
                avm_read <= 1'b0;
              end
            end
          end else if (pending_nxt < MAX_PEND) begin
            avm_read    <= 1'b1;
            avm_address <= addr_of(rd_idx);
          end
        end
        DRAIN: begin
          if ((pending == 5'd0) && (chk_idx == END_IDX)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == 16'd0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_mm_mem_tester.sv
// Bench for avalon_mm_mem_tester: scenario table driven against a behavioural Avalon slave
// with a write scoreboard, memory model, configurable latency, stalls, corruption and spurious beats.
module tb_avalon_mm_mem_tester;

  localparam int          AW   = 26;
  localparam int          NW   = 8;
  localparam int          MP   = 4;
  localparam logic [31:0] SEED = 32'h5A5A_5A5A;

  logic          clk = 1'b0;
  logic          reset_reset, start;
  logic          busy, done, pass;
  logic [15:0]   error_count;
  logic [AW-1:0] first_err_addr, avm_address;
  logic          avm_read, avm_write;
  logic [31:0]   avm_writedata;
  logic [3:0]    avm_byteenable;
  logic          avm_burstcount, avm_debugaccess;
  logic          avm_waitrequest, avm_readdatavalid;
  logic [31:0]   avm_readdata;

  avalon_mm_mem_tester #(
    .ADDR_W(AW), .DATA_W(32), .BASE_ADDR(26'h0), .NUM_WORDS(NW),
    .MAX_PENDING(MP), .SEED(SEED)
  ) dut (
    .clk_clk(clk), .reset_reset(reset_reset), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .first_err_addr(first_err_addr),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_burstcount(avm_burstcount), .avm_debugaccess(avm_debugaccess),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    int            lat;
    bit            stall;
    bit            corrupt;
    bit            spur;
    logic [15:0]   exp_err;
    logic [AW-1:0] exp_fea;
    bit            exp_pass;
  } scen_t;

  typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] data; int due; } resp_t;

  int checks = 0;
  int errors = 0;

  wr_t   exp_wr[$];
  resp_t resp_q[$];
  logic [31:0] mem [NW];

  int  cyc = 0, lat = 2, req_num = 0, stall_done = 0;
  int  wr_seen = 0, rd_seen = 0, outstanding = 0, max_out = 0, max_rd_out = 0;
  int  first_wr_cyc = 0, last_wr_cyc = 0;
  bit  stall_mode = 0, corrupt = 0, spur_after_last = 0, inject = 0;
  logic [63:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_p(input int i);
    logic [15:0] lo;
    lo = i[15:0];
    return {~lo, lo} ^ SEED;
  endfunction

  // Behavioural slave: reacts on the falling edge, so the DUT samples stable inputs.
  initial begin
    resp_t r;
    wr_t   e;
    logic [31:0] d;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (avm_read && !reset_reset && outstanding > max_rd_out) max_rd_out = outstanding;
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
        r = resp_q.pop_front();
        avm_readdatavalid = 1'b1;
        avm_readdata      = r.data;
        outstanding--;
        if (spur_after_last && resp_q.size() == 0 && rd_seen == NW) begin
          inject = 1;
          spur_after_last = 0;
        end
      end else if (inject) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hDEAD_BEEF;
        inject = 0;
      end

      if (!(avm_read || avm_write) || reset_reset) begin
        avm_waitrequest = reset_reset;
      end else if (stall_mode && req_num[0] && stall_done < 3) begin
        avm_waitrequest = 1'b1;
        if (stall_done == 0) held = {2'b0, avm_read, avm_write, avm_address, avm_writedata};
        else check("stall_hold", {2'b0, avm_read, avm_write, avm_address, avm_writedata}, held);
        stall_done++;
      end else begin
        if (stall_done > 0)
          check("stall_hold", {2'b0, avm_read, avm_write, avm_address, avm_writedata}, held);
        stall_done = 0;
        avm_waitrequest = 1'b0;
        req_num++;
        check("byteenable", avm_byteenable, 4'hF);
        if (avm_write) begin
          if (exp_wr.size() == 0) begin
            check("wr_extra", 1, 0);
          end else begin
            e = exp_wr.pop_front();
            check("wr_addr", avm_address, e.addr);
            check("wr_data", avm_writedata, e.data);
            if (wr_seen == 1) check("word1_data", avm_writedata, 32'hA5A4_5A5B);
            if (wr_seen < NW) mem[wr_seen] = avm_writedata;
            if (wr_seen == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            wr_seen++;
          end
        end else begin
          check("rd_addr", avm_address, AW'(4 * rd_seen));
          d = (rd_seen < NW) ? mem[rd_seen] : 32'h0;
          if (corrupt && (avm_address == 26'h14 || avm_address == 26'h18)) d = d ^ 32'h0000_0100;
          resp_q.push_back('{d, cyc + lat});
          rd_seen++;
          outstanding++;
          if (outstanding > max_out) max_out = outstanding;
        end
      end
    end
  end

  task automatic setup(input scen_t s);
    lat = s.lat; stall_mode = s.stall; corrupt = s.corrupt; spur_after_last = s.spur;
    wr_seen = 0; rd_seen = 0; req_num = 0; stall_done = 0; max_out = 0; max_rd_out = 0;
    exp_wr.delete();
    for (int i = 0; i < NW; i++) begin
      mem[i] = '0;
      exp_wr.push_back('{AW'(4 * i), model_p(i)});
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #1;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_write", avm_write, 1);
    check("start_addr", avm_address, 26'h0);
    #1 start = 1'b0;
  endtask

  task automatic run_test(input scen_t s);
    int n;
    setup(s);
    pulse_start();
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({s.name, "_done"}, done, 1);
    check({s.name, "_busy"}, busy, 0);
    check({s.name, "_pass"}, pass, s.exp_pass);
    check({s.name, "_errcnt"}, error_count, s.exp_err);
    check({s.name, "_firsterr"}, first_err_addr, s.exp_fea);
    check({s.name, "_idle_bus"}, {avm_read, avm_write, avm_byteenable}, 6'b0);
    check({s.name, "_writes"}, wr_seen, NW);
    check({s.name, "_reads"}, rd_seen, NW);
    check({s.name, "_pend_max"}, max_out <= MP, 1);
    if (!s.stall) check({s.name, "_wr_b2b"}, last_wr_cyc - first_wr_cyc, NW - 1);
    if (s.lat >= 10) begin
      check({s.name, "_pend_full"}, max_out, MP);
      check({s.name, "_rd_hold"}, max_rd_out, MP - 1);
    end
  endtask

  scen_t tbl[6];
  scen_t s;

  initial begin
    int n;
    tbl[0] = '{"basic",     2,  1'b0, 1'b0, 1'b0, 16'd0, 26'h00, 1'b1};
    tbl[1] = '{"stall",     2,  1'b1, 1'b0, 1'b0, 16'd0, 26'h00, 1'b1};
    tbl[2] = '{"lat10",     10, 1'b0, 1'b0, 1'b0, 16'd0, 26'h00, 1'b1};
    tbl[3] = '{"corrupt",   2,  1'b0, 1'b1, 1'b0, 16'd2, 26'h14, 1'b0};
    tbl[4] = '{"stall_cor", 3,  1'b1, 1'b1, 1'b0, 16'd2, 26'h14, 1'b0};
    tbl[5] = '{"spur_drn",  2,  1'b0, 1'b0, 1'b1, 16'd1, 26'h00, 1'b0};

    reset_reset = 1'b1;
    start       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {busy, done, pass, avm_read, avm_write}, 5'b0);
    check("rst_err", error_count, 16'd0);
    check("rst_fea", first_err_addr, 26'h0);
    check("rst_addr", avm_address, 26'h0);
    check("rst_wdata", avm_writedata, 32'h0);
    check("rst_const", {avm_byteenable, avm_burstcount, avm_debugaccess}, 6'b0000_10);
    #1 reset_reset = 1'b0;

    // A stray readdatavalid while idle must not count.
    @(posedge clk); #2 inject = 1;
    repeat (3) @(posedge clk);
    #1 check("idle_spur_err", error_count, 16'd0);

    for (int i = 0; i < 6; i++) run_test(tbl[i]);

    // Reset while three reads are outstanding, then a clean rerun.
    s = '{"reset_mid", 10, 1'b0, 1'b0, 1'b0, 16'd0, 26'h00, 1'b1};
    setup(s);
    pulse_start();
    n = 0;
    while (!(rd_seen > 0 && outstanding == 3) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("rstmid_reach3", outstanding, 3);
    #1 reset_reset = 1'b1;
    @(posedge clk); #1;
    check("rstmid_read", avm_read, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_err", error_count, 16'd0);
    #1 reset_reset = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("rstmid_late_beats", error_count, 16'd0);
    run_test(s);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
